bcd_down_counter: RTL

//  Synchronous multi-digit BCD (decade) down counter. It counts from a loaded value toward 0.
//  It is the count-down counterpart of the mod-10 up counter, used for timers and remaining-count displays.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_down.sv | 40 ++++
 rtl/bcd_down_counter.sv | 69 ++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and per-digit helpers for the decade down counter.
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Out-of-range codes (A..F) are forced to the largest legal digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

    function automatic bcd_digit_t bcd_dec(input bcd_digit_t v);
        return (v == BCD_ZERO) ? BCD_MAX : v - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade of the down counter: load (clamped), set-to-nine, or decrement with 0->9 wrap.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       set9,
    input  logic       dec_in,
    output bcd_digit_t d,
    output logic       is_zero
);

    bcd_digit_t d_q;
    bcd_digit_t d_d;

    always_comb begin
        d_d = d_q;
        if (ld) begin
            d_d = bcd_clamp(ld_val);
        end else if (set9) begin
            d_d = BCD_MAX;
        end else if (dec_in) begin
            d_d = bcd_dec(d_q);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            d_q <= BCD_ZERO;
        end else begin
            d_q <= d_d;
        end
    end

    assign d       = d_q;
    assign is_zero = (d_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down counter with registered underflow pulse.
// Define BCD_DOWN_HOLD_AT_ZERO_EN to saturate at zero instead of wrapping to all-nines.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                preset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                in,
    output logic [4*DIGITS-1:0] q,
    output logic                zero,
    output logic                borrow
);

    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] zero_below;
    logic              count_en;
    logic              underflow;
    logic              borrow_q;
    logic              borrow_d;

    assign zero = &is_zero;

`ifdef BCD_DOWN_HOLD_AT_ZERO_EN
    assign count_en = in & ~zero;
`else
    // At zero every digit sees an all-zero prefix, so the chain wraps to all-nines by itself.
    assign count_en = in;
`endif

    // zero_below[i]: every digit less significant than i is zero, so digit i must borrow.
    always_comb begin
        zero_below[0] = 1'b1;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            zero_below[i] = zero_below[i-1] & is_zero[i-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk     (clk),
            .clear   (clear),
            .ld      (load),
            .ld_val  (load_val[4*g +: 4]),
            .set9    (preset),
            .dec_in  (count_en & zero_below[g]),
            .d       (q[4*g +: 4]),
            .is_zero (is_zero[g])
        );
    end

    assign underflow = in & zero & ~load & ~preset;
    assign borrow_d  = underflow;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= borrow_d;
        end
    end

    assign borrow = borrow_q;

endmodule
